oled_char_writer: RTL and testbench
===================================

OLED_CHAR_WRITER -- requirements
Module: oled_char_writer

Interface
REQ-001 Parameter COL_OFFSET, default 0, constant added to the column address sent to the panel (2 for SH1106-class panels).
REQ-002 clk_50m  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to draw one 8x16 glyph; sampled only in IDLE.
REQ-005 ascii  input  8  character code; latched on start accept.
REQ-006 page  input  3  top page of the glyph (0..6); latched on start accept.
REQ-007 col  input  7  left column of the glyph (0..120); latched on start accept.
REQ-008 font_ascii  output  8  latched character code, driven to the font ROM.
REQ-009 font_row  output  1  glyph half selector to the ROM (0 = upper page, 1 = lower page).
REQ-010 font_index  output  5  column index 0..7 to the ROM.
REQ-011 font_data  input  8  ROM column byte, valid one clock after font_ascii/font_row/font_index are presented.
REQ-012 tx_valid  output  1  byte available to the panel transport.
REQ-013 tx_dc  output  1  0 = command byte, 1 = display-data byte.
REQ-014 tx_byte  output  8  byte to transmit.
REQ-015 tx_ready  input  1  transport accepts the byte when tx_valid and tx_ready are both high on the same edge.
REQ-016 busy  output  1  high from start accept until done.
REQ-017 done  output  1  one-cycle pulse after the final byte handshake.
REQ-018 err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-019 The block SHALL use the states IDLE, CMD, FETCH, LOAD, DATA and FIN.
REQ-020 In IDLE, start=1 with page<=6 and col<=120 SHALL latch ascii/page/col, set busy, clear font_row, and enter CMD on the same edge.
REQ-021 In IDLE, start=1 with page>6 or col>120 SHALL pulse err for one cycle, leave busy at 0, and emit no bytes.
REQ-022 The start input SHALL be ignored while busy=1.
REQ-023 CMD SHALL emit three command bytes (tx_dc=0) in order: 0xB0|(page+font_row), 0x00|(c[3:0]), and 0x10|(c[7:4]), where c = col+COL_OFFSET computed 8 bits wide.
REQ-024 After the third command handshake, the block SHALL clear font_index and enter FETCH.
REQ-025 FETCH SHALL last one cycle, with font_ascii, font_row and font_index stable.
REQ-026 LOAD SHALL last one cycle, capture font_data into tx_byte, and set tx_dc=1 and tx_valid=1 on exit.
REQ-027 The block SHALL remain in DATA until the handshake completes.
REQ-028 A DATA handshake with font_index<7 SHALL increment font_index and return to FETCH.
REQ-029 A DATA handshake with font_index=7 SHALL go to CMD with font_row=1 if font_row=0, and to FIN otherwise.
REQ-030 Once tx_valid is high, tx_valid, tx_dc and tx_byte SHALL stay constant until the handshake completes.
REQ-031 tx_valid SHALL be low in FETCH, LOAD, FIN and IDLE.
REQ-032 FIN SHALL pulse done for one cycle, clear busy, and return to IDLE; start is not accepted in FIN.
REQ-033 A glyph SHALL produce exactly 22 transfers: (3 commands + 8 data bytes) x 2 halves.
REQ-034 With tx_ready held at 1, the cycle after the accept edge is cycle 1: commands occur at cycles 1-3 and 28-30, data bytes at every third cycle starting at cycle 6 and at cycle 33, and done at cycle 55.
REQ-035 Holding tx_ready low SHALL stall the block indefinitely with no byte lost or duplicated.

Reset
REQ-036 While rst=1, the block SHALL enter IDLE with tx_valid, tx_dc, busy, done, err, font_row = 0, tx_byte, font_ascii = 0x00, and font_index = 0.
REQ-037 rst asserted mid-glyph, including while tx_valid=1, SHALL abort the glyph on that edge without a done pulse; the next start SHALL begin again at the first command.

Verification
REQ-038 Scenario: tx_ready=1, start with ascii="0", page=2, col=16, COL_OFFSET=0 -> bytes B2,00,11,00,E0,10,08,08,10,E0,00,B3,00,11,00,0F,10,20,20,10,0F,00; tx_dc pattern 3x0,8x1,3x0,8x1; done at cycle 55.
REQ-039 Scenario: tx_ready toggling pseudo-randomly -> the same 22-byte stream in order, and tx_byte never changes while tx_valid=1 and tx_ready=0.
REQ-040 Scenario: start with page=7, and separately with col=121 -> an err pulse each time, no tx_valid, busy stays 0.
REQ-041 Scenario: start pulsed again during busy -> ignored, exactly 22 transfers, one done.
REQ-042 Scenario: rst asserted at the 9th handshake -> all outputs reset next edge, no done; a new start yields a full stream from 0xB0|page.
REQ-043 Scenario: COL_OFFSET=2, col=120 -> column commands 0x0A and 0x17.

Source files
------------

// File: rtl/oled_char_writer_if.sv
// Request, font-ROM and panel-transport signals of the OLED glyph writer.
interface oled_char_writer_if;
    logic       start;
    logic [7:0] ascii;
    logic [2:0] page;
    logic [6:0] col;
    logic [7:0] font_ascii;
    logic       font_row;
    logic [4:0] font_index;
    logic [7:0] font_data;
    logic       tx_valid;
    logic       tx_dc;
    logic [7:0] tx_byte;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;

    // Writer side
    modport master (
        input  start, ascii, page, col, font_data, tx_ready,
        output font_ascii, font_row, font_index, tx_valid, tx_dc, tx_byte,
               busy, done, err
    );

    // Requester / ROM / transport side
    modport slave (
        output start, ascii, page, col, font_data, tx_ready,
        input  font_ascii, font_row, font_index, tx_valid, tx_dc, tx_byte,
               busy, done, err
    );
endinterface

// File: rtl/oled_char_writer.sv
// Draws one 8x16 glyph on a page-addressed OLED: per half, three addressing
// commands followed by eight font columns fetched from a 1-cycle-latency ROM.
module oled_char_writer #(
    parameter int unsigned COL_OFFSET = 0
) (
    input  logic             clk_50m,
    input  logic             rst,
    oled_char_writer_if.master bus
);

    localparam int unsigned MAX_PAGE = 6;
    localparam int unsigned MAX_COL  = 120;
    localparam int unsigned LAST_CMD = 2;
    localparam int unsigned LAST_IDX = 7;

    typedef enum logic [2:0] {IDLE, CMD, FETCH, LOAD, DATA, FIN} state_t;

    state_t     state, state_n;
    logic [2:0] page_r, page_n;
    logic [6:0] col_r, col_n;
    logic [7:0] ascii_r, ascii_n;
    logic       row_r, row_n;
    logic [4:0] idx_r, idx_n;
    logic [1:0] cmd_r, cmd_n;
    logic       valid_r, valid_n;
    logic       dc_r, dc_n;
    logic [7:0] byte_r, byte_n;
    logic       busy_r, busy_n;
    logic       done_r, done_n;
    logic       err_r, err_n;

    logic start_ok_c;
    logic hs_c;
    logic last_cmd_c;
    logic last_idx_c;

    assign start_ok_c = (bus.page <= 3'(MAX_PAGE)) && (bus.col <= 7'(MAX_COL));
    assign hs_c       = valid_r & bus.tx_ready;
    assign last_cmd_c = (cmd_r == 2'(LAST_CMD));
    assign last_idx_c = (idx_r == 5'(LAST_IDX));

    // Addressing command byte number idx for the given page/half/column
    function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [2:0] pg,
                                            input logic row, input logic [6:0] cl);
        logic [7:0] c;
        logic [2:0] p;
        c = 8'(cl) + 8'(COL_OFFSET);
        p = pg + 3'(row);
        case (idx)
            2'd0:    cmd_byte = {5'b10110, p};
            2'd1:    cmd_byte = {4'h0, c[3:0]};
            default: cmd_byte = {4'h1, c[7:4]};
        endcase
    endfunction

    // State and registered outputs
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state   <= IDLE;
            page_r  <= '0;
            col_r   <= '0;
            ascii_r <= '0;
            row_r   <= 1'b0;
            idx_r   <= '0;
            cmd_r   <= '0;
            valid_r <= 1'b0;
            dc_r    <= 1'b0;
            byte_r  <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state   <= state_n;
            page_r  <= page_n;
            col_r   <= col_n;
            ascii_r <= ascii_n;
            row_r   <= row_n;
            idx_r   <= idx_n;
            cmd_r   <= cmd_n;
            valid_r <= valid_n;
            dc_r    <= dc_n;
            byte_r  <= byte_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
            err_r   <= err_n;
        end
    end

    // Next-state selection
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start && start_ok_c) state_n = CMD;
            CMD:     if (hs_c && last_cmd_c) state_n = FETCH;
            FETCH:   state_n = LOAD;
            LOAD:    state_n = DATA;
            DATA: begin
                if (hs_c) begin
                    if (!last_idx_c) state_n = FETCH;
                    else if (!row_r) state_n = CMD;
                    else             state_n = FIN;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values of the datapath and output registers
    always_comb begin
        page_n  = page_r;
        col_n   = col_r;
        ascii_n = ascii_r;
        row_n   = row_r;
        idx_n   = idx_r;
        cmd_n   = cmd_r;
        valid_n = valid_r;
        dc_n    = dc_r;
        byte_n  = byte_r;
        busy_n  = busy_r;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (start_ok_c) begin
                        page_n  = bus.page;
                        col_n   = bus.col;
                        ascii_n = bus.ascii;
                        row_n   = 1'b0;
                        busy_n  = 1'b1;
                        cmd_n   = '0;
                        valid_n = 1'b1;
                        dc_n    = 1'b0;
                        byte_n  = cmd_byte(2'd0, bus.page, 1'b0, bus.col);
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            CMD: begin
                if (hs_c) begin
                    if (last_cmd_c) begin
                        valid_n = 1'b0;
                        idx_n   = '0;
                    end else begin
                        cmd_n  = cmd_r + 2'd1;
                        byte_n = cmd_byte(cmd_r + 2'd1, page_r, row_r, col_r);
                    end
                end
            end
            LOAD: begin
                byte_n  = bus.font_data;
                dc_n    = 1'b1;
                valid_n = 1'b1;
            end
            DATA: begin
                if (hs_c) begin
                    valid_n = 1'b0;
                    if (!last_idx_c) begin
                        idx_n = idx_r + 5'd1;
                    end else if (!row_r) begin
                        row_n   = 1'b1;
                        cmd_n   = '0;
                        valid_n = 1'b1;
                        dc_n    = 1'b0;
                        byte_n  = cmd_byte(2'd0, page_r, 1'b1, col_r);
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            FIN: begin
                busy_n = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.font_ascii = ascii_r;
    assign bus.font_row   = row_r;
    assign bus.font_index = idx_r;
    assign bus.tx_valid   = valid_r;
    assign bus.tx_dc      = dc_r;
    assign bus.tx_byte    = byte_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.err        = err_r;

endmodule

// File: tb/tb_oled_char_writer.sv
// Bench for oled_char_writer: scoreboard of expected transport bytes.
module tb_oled_char_writer;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    oled_char_writer_if b0();
    oled_char_writer_if b2();

    oled_char_writer #(.COL_OFFSET(0)) dut0 (.clk_50m(clk), .rst(rst), .bus(b0));
    oled_char_writer #(.COL_OFFSET(2)) dut2 (.clk_50m(clk), .rst(rst), .bus(b2));

    typedef struct packed {
        logic       dc;
        logic [7:0] b;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int base = 0;
    int hs_cnt = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int done_cnt = 0;
    int done_rel = -1;
    logic rnd = 1'b0;
    logic stalled = 1'b0;
    logic [8:0] prev = '0;

    // Font ROM model: glyph "0" from the panel font, a simple pattern otherwise
    function automatic logic [7:0] rom(input logic [7:0] a, input logic r, input logic [4:0] i);
        logic [7:0] t [16];
        t = '{8'h00, 8'hE0, 8'h10, 8'h08, 8'h08, 8'h10, 8'hE0, 8'h00,
              8'h00, 8'h0F, 8'h10, 8'h20, 8'h20, 8'h10, 8'h0F, 8'h00};
        if (a == 8'h30) rom = t[{r, i[2:0]}];
        else            rom = a ^ {3'b000, r, i[3:0]};
    endfunction

    always_ff @(posedge clk) b0.font_data <= rom(b0.font_ascii, b0.font_row, b0.font_index);
    assign b2.font_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd) b0.tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_glyph(input logic [7:0] a, input logic [2:0] pg, input logic [6:0] cl,
                              input logic timed);
        exp_t e;
        logic [7:0] c;
        c = 8'(cl);
        for (int h = 0; h < 2; h++) begin
            for (int j = 0; j < 11; j++) begin
                e.dc = (j >= 3);
                if (j == 0)      e.b = 8'hB0 + 8'(pg) + 8'(h);
                else if (j == 1) e.b = 8'h00 | (c & 8'h0F);
                else if (j == 2) e.b = 8'h10 | (c >> 4);
                else             e.b = rom(a, 1'(h), 5'(j - 3));
                if (timed) e.cyc = h * 27 + ((j < 3) ? (1 + j) : (6 + 3 * (j - 3)));
                else       e.cyc = -1;
                sb.push_back(e);
            end
        end
    endtask

    task automatic start_glyph(input logic [7:0] a, input logic [2:0] pg, input logic [6:0] cl);
        step();
        b0.start = 1'b1;
        b0.ascii = a;
        b0.page  = pg;
        b0.col   = cl;
        base = cyc + 1;
        step();
        b0.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        int d0;
        n = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        check("done_timeout", 32'(n < budget), 32'd1);
        step();
        step();
    endtask

    // Transport monitor: scoreboard pop, stall stability, event counters
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            sb.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", 32'(b0.tx_valid), 32'd1);
                check("hold_byte", 32'({b0.tx_dc, b0.tx_byte}), 32'(prev));
            end
            if (b0.tx_valid) valid_cnt++;
            if (b0.err) err_cnt++;
            if (b0.done) begin
                done_cnt++;
                done_rel = cyc - base;
            end
            if (b0.tx_valid && b0.tx_ready) begin
                exp_t e;
                hs_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_xfer", 32'({b0.tx_dc, b0.tx_byte}), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("xfer_byte", 32'({b0.tx_dc, b0.tx_byte}), 32'({e.dc, e.b}));
                    if (e.cyc >= 0) check("xfer_cycle", 32'(cyc - base), 32'(e.cyc));
                end
            end
            stalled = b0.tx_valid && !b0.tx_ready;
            prev = {b0.tx_dc, b0.tx_byte};
        end
    end

    initial begin
        int h0, d0, e0, v0, n;
        logic seen;
        rst = 1'b1;
        b0.start = 1'b0; b0.ascii = '0; b0.page = '0; b0.col = '0; b0.tx_ready = 1'b1;
        b2.start = 1'b0; b2.ascii = '0; b2.page = '0; b2.col = '0; b2.tx_ready = 1'b1;
        step(); step(); step();

        // Reset state
        check("rst_valid", 32'(b0.tx_valid), 32'd0);
        check("rst_dc", 32'(b0.tx_dc), 32'd0);
        check("rst_byte", 32'(b0.tx_byte), 32'd0);
        check("rst_busy", 32'(b0.busy), 32'd0);
        check("rst_done", 32'(b0.done), 32'd0);
        check("rst_err", 32'(b0.err), 32'd0);
        check("rst_row", 32'(b0.font_row), 32'd0);
        check("rst_ascii", 32'(b0.font_ascii), 32'd0);
        check("rst_index", 32'(b0.font_index), 32'd0);
        rst = 1'b0;
        step();

        // Glyph "0" at page 2 col 16 with a free-running transport
        h0 = hs_cnt; d0 = done_cnt;
        push_glyph(8'h30, 3'd2, 7'd16, 1'b1);
        start_glyph(8'h30, 3'd2, 7'd16);
        check("busy_after_accept", 32'(b0.busy), 32'd1);
        wait_done(200);
        check("done_cycle", 32'(done_rel), 32'd55);
        check("t1_xfers", 32'(hs_cnt - h0), 32'd22);
        check("t1_dones", 32'(done_cnt - d0), 32'd1);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);
        check("t1_busy_end", 32'(b0.busy), 32'd0);

        // Randomly stalling transport
        h0 = hs_cnt;
        rnd = 1'b1;
        push_glyph(8'h30, 3'd2, 7'd16, 1'b0);
        start_glyph(8'h30, 3'd2, 7'd16);
        wait_done(2000);
        rnd = 1'b0;
        b0.tx_ready = 1'b1;
        check("t2_xfers", 32'(hs_cnt - h0), 32'd22);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Out-of-range starts
        e0 = err_cnt; v0 = valid_cnt;
        start_glyph(8'h41, 3'd7, 7'd0);
        step(); step(); step();
        check("page7_err", 32'(err_cnt - e0), 32'd1);
        check("page7_busy", 32'(b0.busy), 32'd0);
        e0 = err_cnt;
        start_glyph(8'h41, 3'd0, 7'd121);
        step(); step(); step();
        check("col121_err", 32'(err_cnt - e0), 32'd1);
        check("col121_busy", 32'(b0.busy), 32'd0);
        check("bad_start_no_valid", 32'(valid_cnt - v0), 32'd0);

        // Start pulsed again while busy
        h0 = hs_cnt; d0 = done_cnt;
        push_glyph(8'h41, 3'd0, 7'd0, 1'b0);
        start_glyph(8'h41, 3'd0, 7'd0);
        step(); step(); step();
        b0.start = 1'b1; b0.ascii = 8'h42; b0.page = 3'd5; b0.col = 7'd64;
        step();
        b0.start = 1'b0;
        check("busy_ascii_kept", 32'(b0.font_ascii), 32'h41);
        wait_done(200);
        check("t4_xfers", 32'(hs_cnt - h0), 32'd22);
        check("t4_dones", 32'(done_cnt - d0), 32'd1);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);

        // Reset on the 9th handshake
        h0 = hs_cnt; d0 = done_cnt;
        push_glyph(8'h30, 3'd4, 7'd40, 1'b0);
        start_glyph(8'h30, 3'd4, 7'd40);
        n = 0;
        while (hs_cnt - h0 < 8 && n < 200) begin step(); n++; end
        check("t5_reach8", 32'(hs_cnt - h0), 32'd8);
        n = 0;
        while (!b0.tx_valid && n < 20) begin step(); n++; end
        check("t5_ninth_valid", 32'(b0.tx_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", 32'(b0.tx_valid), 32'd0);
        check("mid_rst_dc", 32'(b0.tx_dc), 32'd0);
        check("mid_rst_byte", 32'(b0.tx_byte), 32'd0);
        check("mid_rst_busy", 32'(b0.busy), 32'd0);
        check("mid_rst_row", 32'(b0.font_row), 32'd0);
        check("mid_rst_ascii", 32'(b0.font_ascii), 32'd0);
        check("mid_rst_index", 32'(b0.font_index), 32'd0);
        check("mid_rst_sb_flushed", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 60; i++) step();
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_rst_xfers", 32'(hs_cnt - h0), 32'd8);
        h0 = hs_cnt;
        push_glyph(8'h30, 3'd4, 7'd40, 1'b1);
        start_glyph(8'h30, 3'd4, 7'd40);
        wait_done(200);
        check("t5_restart_xfers", 32'(hs_cnt - h0), 32'd22);
        check("t5_restart_sb_empty", 32'(sb.size()), 32'd0);
        check("t5_restart_done_cycle", 32'(done_rel), 32'd55);

        // Column offset of 2 at col 120
        step();
        b2.start = 1'b1; b2.ascii = 8'h30; b2.page = 3'd0; b2.col = 7'd120;
        step();
        b2.start = 1'b0;
        check("off_cmd0", 32'({b2.tx_valid, b2.tx_dc, b2.tx_byte}), 32'h2B0);
        step();
        check("off_cmd1", 32'({b2.tx_valid, b2.tx_dc, b2.tx_byte}), 32'h20A);
        step();
        check("off_cmd2", 32'({b2.tx_valid, b2.tx_dc, b2.tx_byte}), 32'h217);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            step();
            if (b2.done) seen = 1'b1;
            n++;
        end
        check("off_done", 32'(seen), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
